// File: rtl/cpu_stack_engine.sv
// 6502 hardware-stack sequencer: 1/2/3-byte push/pop against page STACK_PAGE with a private SP copy.
// Optional wrap detection on stack_fault is built only when STACK_GUARD_EN is defined.
module cpu_stack_engine #(
   parameter logic [7:0] STACK_PAGE = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] push_word,
   input  logic [7:0]  push_byte,
   input  logic [7:0]  sp_in,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        sp_push,
   output logic        sp_pop,
   output logic [7:0]  pop_byte,
   output logic [15:0] pop_word,
   output logic        done,
   output logic        stack_fault
);

   typedef enum logic [2:0] {IDLE, PUSH, POP, DRAIN, DONE} state_t;

   state_t      state, state_next;
   logic [1:0]  len_q;       // byte count minus one
   logic [15:0] word_q;
   logic [7:0]  byte_q;
   logic [7:0]  sp_q;
   logic [7:0]  sp_inc;
   logic [1:0]  issue_cnt;
   logic [1:0]  cap_cnt;
   logic [1:0]  cap_slot;
   logic        cap_en;
   logic        last;
   logic        accept;

   assign sp_inc = sp_q + 8'd1;
   assign last   = (issue_cnt == len_q);
   assign accept = (state == IDLE) && cmd_valid;
   assign cap_en = ((state == POP) && (issue_cnt != 2'd0)) || (state == DRAIN);
   // POP2 has no P byte, so its first capture lands in the PC low slot
   assign cap_slot = (len_q == 2'd1) ? cap_cnt + 2'd1 : cap_cnt;

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      mem_addr   = {STACK_PAGE, 8'h00};
      mem_wdata  = 8'h00;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      sp_push    = 1'b0;
      sp_pop     = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_op[1:0] == 2'b11)
                  state_next = DONE;
               else if (cmd_op[2])
                  state_next = POP;
               else
                  state_next = PUSH;
            end
         end
         PUSH: begin
            mem_addr = {STACK_PAGE, sp_q};
            mem_we   = 1'b1;
            sp_push  = 1'b1;
            if (len_q == 2'd0)
               mem_wdata = byte_q;
            else if (issue_cnt == 2'd0)
               mem_wdata = word_q[15:8];
            else if (issue_cnt == 2'd1)
               mem_wdata = word_q[7:0];
            else
               mem_wdata = byte_q;
            if (last)
               state_next = DONE;
         end
         POP: begin
            mem_addr = {STACK_PAGE, sp_inc};
            mem_re   = 1'b1;
            sp_pop   = 1'b1;
            if (last)
               state_next = DRAIN;
         end
         DRAIN: state_next = DONE;
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= 2'd0;
         word_q    <= 16'h0000;
         byte_q    <= 8'h00;
         sp_q      <= 8'hFF;
         issue_cnt <= 2'd0;
         cap_cnt   <= 2'd0;
         pop_byte  <= 8'h00;
         pop_word  <= 16'h0000;
      end else begin
         state <= state_next;
         if (accept) begin
            len_q     <= cmd_op[1:0];
            word_q    <= push_word;
            byte_q    <= push_byte;
            sp_q      <= sp_in;
            issue_cnt <= 2'd0;
            cap_cnt   <= 2'd0;
         end
         if (state == PUSH) begin
            sp_q      <= sp_q - 8'd1;
            issue_cnt <= issue_cnt + 2'd1;
         end
         if (state == POP) begin
            sp_q      <= sp_inc;
            issue_cnt <= issue_cnt + 2'd1;
         end
         if (cap_en) begin
            cap_cnt <= cap_cnt + 2'd1;
            case (cap_slot)
               2'd0:    pop_byte       <= mem_rdata;
               2'd1:    pop_word[7:0]  <= mem_rdata;
               default: pop_word[15:8] <= mem_rdata;
            endcase
         end
      end
   end

`ifdef STACK_GUARD_EN
   logic fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fault_q <= 1'b0;
      else if ((mem_we && (sp_q == 8'h00)) || (mem_re && (sp_q == 8'hFF)))
         fault_q <= 1'b1;
   end

   assign stack_fault = fault_q;
`else
   assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_stack_engine.sv
// Scoreboard bench for cpu_stack_engine: expected writes/reads/results are queued per command
// and consumed as the DUT strobes them; a register-file SP is rebuilt from sp_push/sp_pop.
module tb_cpu_stack_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'b011;
   logic [15:0] push_word = 16'h0000;
   logic [7:0]  push_byte = 8'h00;
   logic [7:0]  sp_in = 8'h00;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        sp_push;
   logic        sp_pop;
   logic [7:0]  pop_byte;
   logic [15:0] pop_word;
   logic        done;
   logic        stack_fault;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [7:0]  b;
      logic [15:0] w;
   } pop_t;

   wr_t         exp_wr[$];
   logic [15:0] exp_rd[$];
   pop_t        exp_pop[$];
   logic [7:0]  mem [0:255];

`ifdef STACK_GUARD_EN
   localparam logic WRAP_FAULT = 1'b1;
`else
   localparam logic WRAP_FAULT = 1'b0;
`endif

   cpu_stack_engine #(.STACK_PAGE(8'h01)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .push_word(push_word), .push_byte(push_byte), .sp_in(sp_in), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .sp_push(sp_push), .sp_pop(sp_pop), .pop_byte(pop_byte), .pop_word(pop_word),
      .done(done), .stack_fault(stack_fault)
   );

   always #5 clk = ~clk;

   // Page-$01 memory with one-cycle read latency
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic run_cmd(input logic [2:0] op, input logic [15:0] w, input logic [7:0] b,
                          input logic [7:0] sp, output int lat, output logic [7:0] sp_end,
                          output int npush, output int npop);
      wr_t         e;
      pop_t        p;
      logic [15:0] ra;
      lat = -1; sp_end = sp; npush = 0; npop = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; push_word = w; push_byte = b; sp_in = sp;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL ready_at_accept got=%b want=1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; push_word = ~w; push_byte = ~b; sp_in = ~sp;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++;
         if (mem_we && mem_re) begin
            failures++; $display("FAIL we_re_overlap cycle=%0d got=both want=exclusive", k);
         end
         if (mem_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
               failures++; $display("FAIL wr_unexpected addr=%h data=%h want=none", mem_addr, mem_wdata);
            end else begin
               e = exp_wr.pop_front();
               if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                  failures++;
                  $display("FAIL wr got=%h:%h want=%h:%h", mem_addr, mem_wdata, e.addr, e.data);
               end
            end
         end
         if (mem_re) begin
            checks++;
            if (exp_rd.size() == 0) begin
               failures++; $display("FAIL rd_unexpected addr=%h want=none", mem_addr);
            end else begin
               ra = exp_rd.pop_front();
               if (mem_addr !== ra) begin
                  failures++; $display("FAIL rd_addr got=%h want=%h", mem_addr, ra);
               end
            end
         end
         if (sp_push) begin npush++; sp_end = sp_end - 8'd1; end
         if (sp_pop)  begin npop++;  sp_end = sp_end + 8'd1; end
         if (done) begin
            lat = k;
            checks++;
            if (exp_pop.size() == 0) begin
               failures++; $display("FAIL pop_result_unexpected got=%h/%h want=none", pop_byte, pop_word);
            end else begin
               p = exp_pop.pop_front();
               if (pop_byte !== p.b || pop_word !== p.w) begin
                  failures++;
                  $display("FAIL pop_result got=%h/%h want=%h/%h", pop_byte, pop_word, p.b, p.w);
               end
            end
            break;
         end
      end
      checks++;
      if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
         failures++;
         $display("FAIL missing_access got_left=%0d/%0d want=0/0", exp_wr.size(), exp_rd.size());
      end
      exp_wr.delete(); exp_rd.delete(); exp_pop.delete();
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL ready_after_done got=%b/%b want=1/0", cmd_ready, done);
      end
      $display("cmd op=%b sp_in=%h lat=%0d sp_end=%h push=%0d pop=%0d pop_byte=%h pop_word=%h",
               op, sp, lat, sp_end, npush, npop, pop_byte, pop_word);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
      checks++;
      if (mem_addr !== 16'h0100) begin failures++; $display("FAIL rst_addr got=%h want=0100", mem_addr); end
      checks++;
      if (mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata got=%h want=00", mem_wdata); end
      checks++;
      if ({mem_we, mem_re, sp_push, sp_pop, done} !== 5'b0) begin
         failures++; $display("FAIL rst_strobes got=%b want=00000", {mem_we, mem_re, sp_push, sp_pop, done});
      end
      checks++;
      if (pop_byte !== 8'h00 || pop_word !== 16'h0000) begin
         failures++; $display("FAIL rst_pop got=%h/%h want=00/0000", pop_byte, pop_word);
      end
      checks++;
      if (stack_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b want=0", stack_fault); end
      rst = 1'b0;
   endtask

   task automatic test_push1();
      int lat, np, npp; logic [7:0] s;
      exp_wr.push_back('{16'h01FF, 8'hA5});
      exp_pop.push_back('{8'h00, 16'h0000});
      run_cmd(3'b000, 16'h0000, 8'hA5, 8'hFF, lat, s, np, npp);
      checks++;
      if (lat !== 2 || s !== 8'hFE || np !== 1 || npp !== 0) begin
         failures++; $display("FAIL push1 got=lat%0d sp%h p%0d q%0d want=lat2 spFE p1 q0", lat, s, np, npp);
      end
   endtask

   task automatic test_push2();
      int lat, np, npp; logic [7:0] s;
      exp_wr.push_back('{16'h01FD, 8'hC1});
      exp_wr.push_back('{16'h01FC, 8'h23});
      exp_pop.push_back('{8'h00, 16'h0000});
      run_cmd(3'b001, 16'hC123, 8'h77, 8'hFD, lat, s, np, npp);
      checks++;
      if (lat !== 3 || s !== 8'hFB || np !== 2 || npp !== 0) begin
         failures++; $display("FAIL push2 got=lat%0d sp%h p%0d q%0d want=lat3 spFB p2 q0", lat, s, np, npp);
      end
   endtask

   task automatic test_pop2();
      int lat, np, npp; logic [7:0] s;
      exp_rd.push_back(16'h01FC);
      exp_rd.push_back(16'h01FD);
      exp_pop.push_back('{8'h00, 16'hC123});
      run_cmd(3'b101, 16'h0000, 8'h00, 8'hFB, lat, s, np, npp);
      checks++;
      if (lat !== 4 || s !== 8'hFD || np !== 0 || npp !== 2) begin
         failures++; $display("FAIL pop2 got=lat%0d sp%h p%0d q%0d want=lat4 spFD p0 q2", lat, s, np, npp);
      end
   endtask

   task automatic test_round_trip();
      int lat, np, npp; logic [7:0] s;
      exp_wr.push_back('{16'h01FF, 8'h80});
      exp_wr.push_back('{16'h01FE, 8'h01});
      exp_wr.push_back('{16'h01FD, 8'h30});
      exp_pop.push_back('{8'h00, 16'hC123});
      run_cmd(3'b010, 16'h8001, 8'h30, 8'hFF, lat, s, np, npp);
      checks++;
      if (lat !== 4 || s !== 8'hFC || np !== 3) begin
         failures++; $display("FAIL push3 got=lat%0d sp%h p%0d want=lat4 spFC p3", lat, s, np);
      end
      exp_rd.push_back(16'h01FD);
      exp_rd.push_back(16'h01FE);
      exp_rd.push_back(16'h01FF);
      exp_pop.push_back('{8'h30, 16'h8001});
      run_cmd(3'b110, 16'h0000, 8'h00, s, lat, s, np, npp);
      checks++;
      if (lat !== 5 || s !== 8'hFF || npp !== 3) begin
         failures++; $display("FAIL pop3 got=lat%0d sp%h q%0d want=lat5 spFF q3", lat, s, npp);
      end
   endtask

   task automatic test_nop();
      int lat, np, npp; logic [7:0] s;
      logic [2:0] ops [2];
      ops[0] = 3'b011; ops[1] = 3'b111;
      foreach (ops[i]) begin
         exp_pop.push_back('{8'h30, 16'h8001});
         run_cmd(ops[i], 16'h1234, 8'h56, 8'h80, lat, s, np, npp);
         checks++;
         if (lat !== 1 || s !== 8'h80 || np !== 0 || npp !== 0) begin
            failures++; $display("FAIL nop got=lat%0d sp%h p%0d q%0d want=lat1 sp80 p0 q0", lat, s, np, npp);
         end
      end
   endtask

   task automatic test_wrap();
      int lat, np, npp; logic [7:0] s;
      checks++;
      if (stack_fault !== 1'b0) begin failures++; $display("FAIL fault_early got=%b want=0", stack_fault); end
      exp_wr.push_back('{16'h0100, 8'h5A});
      exp_pop.push_back('{8'h30, 16'h8001});
      run_cmd(3'b000, 16'h0000, 8'h5A, 8'h00, lat, s, np, npp);
      checks++;
      if (lat !== 2 || s !== 8'hFF) begin
         failures++; $display("FAIL push_wrap got=lat%0d sp%h want=lat2 spFF", lat, s);
      end
      checks++;
      if (stack_fault !== WRAP_FAULT) begin
         failures++; $display("FAIL push_wrap_fault got=%b want=%b", stack_fault, WRAP_FAULT);
      end
      exp_rd.push_back(16'h0100);
      exp_pop.push_back('{8'h5A, 16'h8001});
      run_cmd(3'b100, 16'h0000, 8'h00, 8'hFF, lat, s, np, npp);
      checks++;
      if (lat !== 3 || s !== 8'h00) begin
         failures++; $display("FAIL pop_wrap got=lat%0d sp%h want=lat3 sp00", lat, s);
      end
      checks++;
      if (stack_fault !== WRAP_FAULT) begin
         failures++; $display("FAIL fault_sticky got=%b want=%b", stack_fault, WRAP_FAULT);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'b110; sp_in = 8'hFC;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || {mem_re, sp_pop, done} !== 3'b000 || mem_addr !== 16'h0100) begin
         failures++;
         $display("FAIL mid_reset got=rdy%b re%b pop%b done%b addr%h want=rdy1 re0 pop0 done0 addr0100",
                  cmd_ready, mem_re, sp_pop, done, mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done || mem_re || !cmd_ready) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL mid_reset_resume got=%0d want=0", seen); end
      checks++;
      if (stack_fault !== 1'b0) begin failures++; $display("FAIL mid_reset_fault got=%b want=0", stack_fault); end
      $display("cmd op=110 reset at T2 idle=%b", cmd_ready);
   endtask

   initial begin
      test_reset();
      test_push1();
      test_push2();
      test_pop2();
      test_round_trip();
      test_nop();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
